// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory-port arbiter.
// The grant rule is kept here so that the FSM and its next-state logic agree.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2,
        RESP    = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    localparam logic [2:0] MEM_WORD = 3'b010;

    // Fetch wins only when alone, or on contention when fairness hands it the turn.
    function automatic logic pick_fetch(input logic if_pend, input logic d_pend,
                                        input logic fair, input owner_t last_owner);
        return if_pend & (~d_pend | (fair & (last_owner == OWN_D)));
    endfunction

endpackage

// File: rtl/arb_timeout_ctr.sv
// Saturating watchdog for the arbiter. It counts enabled cycles and flags the
// cycle in which the TIMEOUT-th consecutive enabled cycle completes.
module arb_timeout_ctr #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] SAT  = CW'(TIMEOUT);

    logic [CW-1:0] cnt_r;

    // Watchdog count: saturates at TIMEOUT so it can never wrap back to zero.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_r <= '0;
        end else if (enable && (cnt_r != SAT)) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = enable && (cnt_r == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and load/store paths onto one registered memory port,
// returning one-cycle completion pulses and aborting stuck transactions.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int FAIR    = 1
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_stall,
    input  logic        d_rd_en,
    input  logic        d_wr_en,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [2:0]  d_type,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_type,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        err_timeout
);

    arb_state_t state_r;
    arb_state_t next_state_s;
    owner_t     last_owner_r;

    logic d_pend_s;
    logic fetch_first_s;
    logic busy_s;
    logic expired_s;
    logic grant_if_s;
    logic grant_d_s;
    logic done_s;
    logic abort_s;

    assign d_pend_s      = d_rd_en | d_wr_en;
    assign fetch_first_s = pick_fetch(if_req, d_pend_s, (FAIR != 0), last_owner_r);
    assign busy_s        = (state_r == BUSY_IF) || (state_r == BUSY_D);

    arb_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk     (CLK),
        .rst     (Reset),
        .clear   (~busy_s),
        .enable  (busy_s & ~mem_ack),
        .expired (expired_s)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; RESP never grants so completions are at least 3 cycles apart.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (fetch_first_s) begin
                    next_state_s = BUSY_IF;
                end else if (d_pend_s) begin
                    next_state_s = BUSY_D;
                end else begin
                    next_state_s = IDLE;
                end
            end
            BUSY_IF, BUSY_D: begin
                if (mem_ack || expired_s) begin
                    next_state_s = RESP;
                end else begin
                    next_state_s = state_r;
                end
            end
            RESP:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Per-state control strobes; an ack in the expiry cycle takes precedence.
    always_comb begin
        grant_if_s = 1'b0;
        grant_d_s  = 1'b0;
        done_s     = 1'b0;
        abort_s    = 1'b0;
        if (state_r == IDLE) begin
            grant_if_s = fetch_first_s;
            grant_d_s  = ~fetch_first_s & d_pend_s;
        end else if (busy_s) begin
            done_s  = mem_ack | expired_s;
            abort_s = ~mem_ack & expired_s;
        end else begin
            grant_if_s = 1'b0;
        end
    end

    // Memory-port, completion and error registers.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            last_owner_r <= OWN_IF;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= 32'h0;
            mem_wdata    <= 32'h0;
            mem_type     <= 3'b000;
            if_rvalid    <= 1'b0;
            if_rdata     <= 32'h0;
            d_rvalid     <= 1'b0;
            d_rdata      <= 32'h0;
            err_timeout  <= 1'b0;
        end else begin
            if (grant_if_s) begin
                mem_req      <= 1'b1;
                mem_we       <= 1'b0;
                mem_addr     <= if_addr;
                mem_wdata    <= 32'h0;
                mem_type     <= MEM_WORD;
                last_owner_r <= OWN_IF;
            end else if (grant_d_s) begin
                mem_req      <= 1'b1;
                mem_we       <= d_wr_en;
                mem_addr     <= d_addr;
                mem_wdata    <= d_wdata;
                mem_type     <= d_type;
                last_owner_r <= OWN_D;
            end else if (done_s) begin
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
                if (state_r == BUSY_IF) begin
                    if_rvalid <= 1'b1;
                    if_rdata  <= abort_s ? 32'h0 : mem_rdata;
                end else begin
                    d_rvalid <= 1'b1;
                    d_rdata  <= abort_s ? 32'h0 : mem_rdata;
                end
            end else if (state_r == RESP) begin
                if_rvalid <= 1'b0;
                d_rvalid  <= 1'b0;
            end else begin
                mem_req <= mem_req;
            end
            if (abort_s) begin
                err_timeout <= 1'b1;
            end else begin
                err_timeout <= err_timeout;
            end
        end
    end

    assign if_stall = if_req & ~if_rvalid;
    assign d_stall  = d_pend_s & ~d_rvalid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a default instance (TIMEOUT=255) and a
// TIMEOUT=4 instance share request inputs but each has its own mem_ack.
module tb_mem_port_arbiter;

    logic        CLK;
    logic        Reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_rd_en;
    logic        d_wr_en;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [2:0]  d_type;
    logic        ack_a;
    logic        ack_b;
    logic [31:0] mem_rdata;

    logic        if_rvalid, d_rvalid, if_stall, d_stall, mem_req, mem_we, err_timeout;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic [2:0]  mem_type;

    logic        t_if_rvalid, t_d_rvalid, t_if_stall, t_d_stall, t_mem_req, t_mem_we, t_err;
    logic [31:0] t_if_rdata, t_d_rdata, t_mem_addr, t_mem_wdata;
    logic [2:0]  t_mem_type;

    int n_checks = 0;
    int n_errors = 0;

    mem_port_arbiter dut (
        .CLK(CLK), .Reset(Reset),
        .if_req(if_req), .if_addr(if_addr), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .if_stall(if_stall), .d_rd_en(d_rd_en), .d_wr_en(d_wr_en), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_type(d_type), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .d_stall(d_stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_type(mem_type), .mem_ack(ack_a),
        .mem_rdata(mem_rdata), .err_timeout(err_timeout)
    );

    mem_port_arbiter #(.TIMEOUT(4), .FAIR(1)) dut_to (
        .CLK(CLK), .Reset(Reset),
        .if_req(if_req), .if_addr(if_addr), .if_rvalid(t_if_rvalid), .if_rdata(t_if_rdata),
        .if_stall(t_if_stall), .d_rd_en(d_rd_en), .d_wr_en(d_wr_en), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_type(d_type), .d_rvalid(t_d_rvalid), .d_rdata(t_d_rdata),
        .d_stall(t_d_stall), .mem_req(t_mem_req), .mem_we(t_mem_we), .mem_addr(t_mem_addr),
        .mem_wdata(t_mem_wdata), .mem_type(t_mem_type), .mem_ack(ack_b),
        .mem_rdata(mem_rdata), .err_timeout(t_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; if_req = 1'b0; if_addr = 32'h0; d_rd_en = 1'b0; d_wr_en = 1'b0;
        d_addr = 32'h0; d_wdata = 32'h0; d_type = 3'b000; ack_a = 1'b0; ack_b = 1'b0;
        mem_rdata = 32'h0;
        tick();
        tick();
        check_val("rst_mem_req", {31'h0, mem_req}, 32'h0);
        check_val("rst_mem_addr", mem_addr, 32'h0);
        check_val("rst_rvalid", {30'h0, if_rvalid, d_rvalid}, 32'h0);
        check_val("rst_err", {31'h0, err_timeout}, 32'h0);
        Reset = 1'b0;

        // Fetch alone, ack in the first busy cycle
        if_req = 1'b1; if_addr = 32'h100;
        tick();
        check_val("f_mem_req", {31'h0, mem_req}, 32'h1);
        check_val("f_mem_addr", mem_addr, 32'h100);
        check_val("f_mem_type", {29'h0, mem_type}, 32'h2);
        check_val("f_if_stall", {31'h0, if_stall}, 32'h1);
        ack_a = 1'b1; mem_rdata = 32'h0050_0093;
        tick();
        check_val("f_if_rvalid", {31'h0, if_rvalid}, 32'h1);
        check_val("f_if_rdata", if_rdata, 32'h0050_0093);
        check_val("f_if_stall_done", {31'h0, if_stall}, 32'h0);
        check_val("f_mem_req_done", {31'h0, mem_req}, 32'h0);
        ack_a = 1'b0; mem_rdata = 32'h0; if_req = 1'b0;
        tick();
        check_val("f_if_rvalid_pulse", {31'h0, if_rvalid}, 32'h0);
        check_val("f_if_rdata_hold", if_rdata, 32'h0050_0093);

        // Store while a fetch waits; last owner was fetch so data wins
        d_wr_en = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF; d_type = 3'b000;
        if_req = 1'b1; if_addr = 32'h104;
        tick();
        check_val("s_mem_we", {31'h0, mem_we}, 32'h1);
        check_val("s_mem_addr", mem_addr, 32'h40);
        check_val("s_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        check_val("s_mem_type", {29'h0, mem_type}, 32'h0);
        check_val("s_if_stall", {31'h0, if_stall}, 32'h1);
        ack_a = 1'b1; mem_rdata = 32'h1234_5678;
        tick();
        check_val("s_d_rvalid", {31'h0, d_rvalid}, 32'h1);
        check_val("s_if_rvalid", {31'h0, if_rvalid}, 32'h0);
        check_val("s_mem_we_clr", {31'h0, mem_we}, 32'h0);
        check_val("s_d_stall", {31'h0, d_stall}, 32'h0);
        ack_a = 1'b0; d_wr_en = 1'b0;
        tick();
        check_val("s_d_rvalid_pulse", {31'h0, d_rvalid}, 32'h0);
        check_val("s_mem_req_idle", {31'h0, mem_req}, 32'h0);
        tick();
        check_val("s_fetch_addr", mem_addr, 32'h104);
        check_val("s_fetch_we", {31'h0, mem_we}, 32'h0);
        check_val("s_fetch_type", {29'h0, mem_type}, 32'h2);
        ack_a = 1'b1; mem_rdata = 32'h0000_0011;
        tick();
        check_val("s_fetch_rdata", if_rdata, 32'h0000_0011);
        ack_a = 1'b0; if_req = 1'b0;
        tick();

        // Contention after reset with both requesters held continuously
        do_reset();
        if_req = 1'b1; if_addr = 32'h200; d_rd_en = 1'b1; d_addr = 32'h2000; d_type = 3'b010;
        tick();
        check_val("c_first_addr", mem_addr, 32'h2000);
        ack_a = 1'b1; mem_rdata = 32'hAAAA_0001;
        tick();
        check_val("c_first_rdata", d_rdata, 32'hAAAA_0001);
        check_val("c_first_rvalid", {31'h0, d_rvalid}, 32'h1);
        ack_a = 1'b0; d_addr = 32'h2004;
        tick();
        check_val("c_resp_gap_req", {31'h0, mem_req}, 32'h0);
        tick();
        check_val("c_second_addr", mem_addr, 32'h200);
        ack_a = 1'b1; mem_rdata = 32'hBBBB_0002;
        tick();
        check_val("c_second_rvalid", {31'h0, if_rvalid}, 32'h1);
        check_val("c_second_rdata", if_rdata, 32'hBBBB_0002);
        ack_a = 1'b0; if_addr = 32'h204;
        tick();
        tick();
        check_val("c_third_addr", mem_addr, 32'h2004);
        ack_a = 1'b1; mem_rdata = 32'hCCCC_0003;
        tick();
        check_val("c_third_rdata", d_rdata, 32'hCCCC_0003);
        check_val("c_third_if_rvalid", {31'h0, if_rvalid}, 32'h0);
        ack_a = 1'b0; if_req = 1'b0; d_rd_en = 1'b0;
        tick();

        // Wait states: ack arrives in the sixth busy cycle
        d_rd_en = 1'b1; d_addr = 32'h80; d_type = 3'b010;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check_val($sformatf("w_mem_req_%0d", k), {31'h0, mem_req}, 32'h1);
            check_val($sformatf("w_d_stall_%0d", k), {31'h0, d_stall}, 32'h1);
            check_val($sformatf("w_d_rvalid_%0d", k), {31'h0, d_rvalid}, 32'h0);
            if (k == 6) begin
                ack_a = 1'b1; mem_rdata = 32'h5A5A_5A5A;
            end
        end
        tick();
        check_val("w_d_rvalid", {31'h0, d_rvalid}, 32'h1);
        check_val("w_d_rdata", d_rdata, 32'h5A5A_5A5A);
        check_val("w_mem_req_clr", {31'h0, mem_req}, 32'h0);
        ack_a = 1'b0; d_rd_en = 1'b0;
        tick();
        check_val("w_d_rvalid_pulse", {31'h0, d_rvalid}, 32'h0);
        check_val("w_no_err", {31'h0, err_timeout}, 32'h0);

        // Reset while BUSY_D, late ack must be ignored
        do_reset();
        d_rd_en = 1'b1; d_addr = 32'h300;
        tick();
        check_val("r_busy", {31'h0, mem_req}, 32'h1);
        Reset = 1'b1; d_rd_en = 1'b0;
        tick();
        check_val("r_mem_req", {31'h0, mem_req}, 32'h0);
        check_val("r_mem_addr", mem_addr, 32'h0);
        Reset = 1'b0; ack_a = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        tick();
        check_val("r_no_rvalid", {30'h0, if_rvalid, d_rvalid}, 32'h0);
        check_val("r_d_rdata", d_rdata, 32'h0);
        check_val("r_mem_req_late", {31'h0, mem_req}, 32'h0);
        ack_a = 1'b0;
        if_req = 1'b1; if_addr = 32'h400;
        tick();
        check_val("r_idle_grant", mem_addr, 32'h400);
        ack_a = 1'b1; mem_rdata = 32'h0000_0001;
        tick();
        check_val("r_idle_rvalid", {31'h0, if_rvalid}, 32'h1);
        ack_a = 1'b0; if_req = 1'b0;
        tick();

        // Timeout on the TIMEOUT=4 instance, preceded by a good load
        do_reset();
        d_rd_en = 1'b1; d_addr = 32'h500;
        tick();
        ack_b = 1'b1; mem_rdata = 32'h0000_0099;
        tick();
        check_val("t_good_rdata", t_d_rdata, 32'h0000_0099);
        ack_b = 1'b0; d_rd_en = 1'b0;
        tick();
        d_rd_en = 1'b1; d_addr = 32'h504;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check_val($sformatf("t_mem_req_%0d", k), {31'h0, t_mem_req}, 32'h1);
            check_val($sformatf("t_err_pre_%0d", k), {31'h0, t_err}, 32'h0);
        end
        tick();
        check_val("t_mem_req_drop", {31'h0, t_mem_req}, 32'h0);
        check_val("t_d_rvalid", {31'h0, t_d_rvalid}, 32'h1);
        check_val("t_d_rdata_zero", t_d_rdata, 32'h0);
        check_val("t_err_set", {31'h0, t_err}, 32'h1);
        d_rd_en = 1'b0;
        tick();
        check_val("t_d_rvalid_pulse", {31'h0, t_d_rvalid}, 32'h0);
        check_val("t_err_sticky", {31'h0, t_err}, 32'h1);
        if_req = 1'b1; if_addr = 32'h600;
        tick();
        check_val("t_next_req", {31'h0, t_mem_req}, 32'h1);
        check_val("t_next_addr", t_mem_addr, 32'h600);
        ack_b = 1'b1; mem_rdata = 32'h0000_0077;
        tick();
        check_val("t_next_rvalid", {31'h0, t_if_rvalid}, 32'h1);
        check_val("t_next_rdata", t_if_rdata, 32'h0000_0077);
        check_val("t_err_still", {31'h0, t_err}, 32'h1);
        ack_b = 1'b0; if_req = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
